time_display: RTL
=================

Name: time_display

Overview:
- Consumer of the per-song elapsed-time values (mins/secs, binary 0..59) produced by the song timer.
- Converts each value to two BCD digits with a small sequential subtract-by-10 engine.
- Drives a 4-digit, active-low, multiplexed seven-segment display as MM.SS, with the decimal point separating minutes from seconds.
- Blanks the whole display at a blink rate while the player is paused; sits between the timer and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is held (100 MHz gives 1 kHz per digit).
- BLINK_DIV, 25000000, clk cycles per blink half-period while paused.

Ports:
- clk  in  1  system clock.
- RESET  in  1  reset, synchronous, active-high.
- mins  in  6  minutes to show, binary.
- secs  in  6  seconds to show, binary.
- pause  in  1  1 = paused, display blinks.
- an  out  4  digit enables, active-low; an[0] = seconds ones, an[3] = minutes tens.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Clocking and reset: single clock domain. RESET is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values (the edge RESET is sampled high):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Digit registers 0, captured mins/secs 0.
  - sel=0, refresh and blink counters 0, blink_phase 0, FSM in IDLE.
- Conversion FSM, states IDLE, CONV:
  - IDLE: if {mins,secs} != captured value, latch mins→m_rem and secs→s_rem, clear m_tens and s_tens, go to CONV. Otherwise stay.
  - CONV, subtract step: on each edge, if m_rem>=10 then m_rem-=10 and m_tens++; same for s_rem/s_tens in parallel.
  - CONV, commit: on the edge where both remainders are <10, write digit[3:0] = {m_tens, m_rem, s_tens, s_rem} and go to IDLE.
- Conversion latency: digits commit on the (max(m_tens,s_tens)+2)th edge, counting the sampling edge as the 1st. 59:59 takes 7 edges; 00:00→00:05 takes 2.
- Input changes during CONV are ignored. On return to IDLE the inputs are compared again, so the newer value starts converting the next edge.
- Out-of-range inputs: 60..63 are converted literally (tens digit 6). Upstream guarantees ≤59; there is no clamping.
- Refresh scan:
  - refresh counter runs 0..REFRESH_DIV-1. On wrap, sel increments 0→1→2→3→0 (2-bit wrap).
  - Output registers load from sel and the digit registers, so an/seg/dp lag sel by one cycle.
  - an is active-low one-hot of sel; seg = decode(digit[sel]); dp=0 only when sel=2, else 1.
  - A conversion commit mid-scan takes effect on the next output register load. No tearing: all four digits commit together.
- Blink:
  - pause=1: blink counter runs 0..BLINK_DIV-1 and toggles blink_phase on wrap. While blink_phase=1, an=4'b1111. Scan and conversion continue underneath.
  - pause=0: blink counter and blink_phase are cleared to 0 at the next edge, so the display is continuously on from the following output load.
- Segment decode ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Other codes =1111111.
- Leading zeros are always shown; idle display reads 00.00.

Decomposition:
- Shared package (musicbox_pkg):
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - NUM_DIGITS=4.
  - FSM state encoding for IDLE/CONV.
- One combinational sub-module, seg7_decode (4-bit digit → 7-bit active-low pattern), reusable by other display blocks.
- Conversion FSM, scan counter and blink logic stay in time_display.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8):
1. Reset and idle: RESET high 3 cycles with mins=0, secs=0 → an=1111, seg=1111111, dp=1 during reset. After release, next load gives an=1110, seg=1000000; each digit is held 4 cycles, dp=0 only while an=1011.
2. Conversion and scan: mins=12, secs=34 → digits commit 5 edges after sampling. Scan then shows:
   - an=1110 seg=0011001 (4)
   - an=1101 seg=0110000 (3)
   - an=1011 seg=0100100 (2), dp=0
   - an=0111 seg=1111001 (1)
3. Worst-case latency: 59:59 → commits on the 7th edge. Then secs→0 → 59:00 commits 7 edges later (m_tens=5 dominates).
4. Input change mid-conversion: secs 59→58 on the 2nd CONV edge → display first commits 00.59, then 00.58 exactly 2+5 edges after returning to IDLE.
5. Pause blink: pause=1 → an alternates 8 cycles scanning / 8 cycles 1111. pause=0 mid-blank → scanning resumes within 2 cycles and stays on.
6. Reset mid-CONV: assert RESET during CONV for 59:59 → next edge gives an=1111, seg=1111111, FSM IDLE. After release, 59:59 reconverts and commits after 7 edges.

Source files
------------

// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box display blocks: segment patterns,
// digit count and the BCD conversion state encoding.
package musicbox_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low seven-segment pattern decoder.
// Codes above 9 are shown blank.
module seg7_decode
    import musicbox_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display.sv
// MM.SS elapsed-time display: sequential binary-to-BCD conversion, multiplexed
// active-low seven-segment scan, and whole-display blink while paused.
module time_display
    import musicbox_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic       pause,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    conv_state_t state, state_nxt;
    logic        start, commit;

    logic [11:0] captured;
    logic [5:0]  m_rem, s_rem;
    logic [3:0]  m_tens, s_tens;
    logic [4*NUM_DIGITS-1:0] digits;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    sel;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [3:0] cur_digit;
    logic [6:0] cur_seg;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if ({mins, secs} != captured) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (m_rem < 6'd10 && s_rem < 6'd10) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture and committed digits: all four digits update on the same edge
    always_ff @(posedge clk) begin
        if (RESET) begin
            captured <= '0;
            digits   <= '0;
        end else if (start) begin
            captured <= {mins, secs};
        end else if (commit) begin
            digits <= {m_tens, m_rem[3:0], s_tens, s_rem[3:0]};
        end
    end

    // Subtract-by-10 engine; minutes and seconds run in parallel
    always_ff @(posedge clk) begin
        if (start) begin
            m_rem  <= mins;
            s_rem  <= secs;
            m_tens <= 4'd0;
            s_tens <= 4'd0;
        end else if (state == CONV && !commit) begin
            if (m_rem >= 6'd10) begin
                m_rem  <= m_rem - 6'd10;
                m_tens <= m_tens + 4'd1;
            end
            if (s_rem >= 6'd10) begin
                s_rem  <= s_rem - 6'd10;
                s_tens <= s_tens + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            refresh_cnt <= '0;
            sel         <= 2'd0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            sel         <= sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET || !pause) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign cur_digit = digits[{sel, 2'b00} +: 4];

    seg7_decode u_dec (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    // Output registers lag sel by one cycle; dp sits left of the seconds tens
    always_ff @(posedge clk) begin
        if (RESET) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= blink_phase ? 4'b1111 : ~(4'b0001 << sel);
            seg <= cur_seg;
            dp  <= (sel != 2'd2);
        end
    end

endmodule
